// File: rtl/soc_bus_decoder.sv
// Address decoder and transaction sequencer between a single core port and NUM_SLAVES slaves.
// Unmapped or timed-out accesses get a one-cycle error response and are logged.
module soc_bus_decoder #(
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] BASE_ADDRS =
    {32'h8000_0010, 32'h8000_0008, 32'h8000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] ADDR_MASKS =
    {32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'hFFFF_E000},
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [31:0] DEFAULT_RDATA = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [NUM_SLAVES-1:0]    slave_sel,
  input  logic [NUM_SLAVES-1:0]    slave_ready,
  input  logic [NUM_SLAVES*32-1:0] slave_rdata,
  output logic                     bus_err,
  output logic                     err_timeout,
  output logic [31:0]              err_addr,
  output logic [15:0]              err_count
);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

  state_t                state;
  logic [31:0]           cnt;
  logic [NUM_SLAVES-1:0] hit_onehot;
  logic                  hit;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;
  logic                  timeout_now;
  logic                  enter_err;
  logic [15:0]           err_count_next;

  // Scan from the top so the lowest-index hit overwrites any higher one.
  always_comb begin
    hit_onehot = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((mem_addr & ADDR_MASKS[32*i +: 32]) == BASE_ADDRS[32*i +: 32]) begin
        hit_onehot    = '0;
        hit_onehot[i] = 1'b1;
      end
    end
  end

  assign hit = |hit_onehot;

  // The registered one-hot select doubles as the stored slave index.
  always_comb begin
    sel_rdata = DEFAULT_RDATA;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slave_sel[i]) sel_rdata = slave_rdata[32*i +: 32];
    end
  end

  assign sel_ready   = |(slave_ready & slave_sel);
  assign timeout_now = (TIMEOUT_CYCLES > 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));

  assign enter_err = ((state == IDLE) && mem_valid && !hit) ||
                     ((state == ACTIVE) && mem_valid && !sel_ready && timeout_now);

  assign err_count_next = (enter_err && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      slave_sel   <= '0;
      cnt         <= '0;
      err_timeout <= 1'b0;
      err_addr    <= '0;
      err_count   <= '0;
    end else begin
      err_count <= err_count_next;
      case (state)
        IDLE: begin
          if (mem_valid) begin
            if (hit) begin
              state     <= ACTIVE;
              slave_sel <= hit_onehot;
              cnt       <= '0;
            end else begin
              state       <= ERR;
              err_addr    <= mem_addr;
              err_timeout <= 1'b0;
            end
          end
        end
        ACTIVE: begin
          // A withdrawn request or a completed one both return quietly to IDLE.
          if (!mem_valid || sel_ready) begin
            state     <= IDLE;
            slave_sel <= '0;
          end else if (timeout_now) begin
            state       <= ERR;
            slave_sel   <= '0;
            err_addr    <= mem_addr;
            err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_ready = 1'b0;
    mem_rdata = DEFAULT_RDATA;
    bus_err   = 1'b0;
    case (state)
      ACTIVE: begin
        if (mem_valid && sel_ready) begin
          mem_ready = 1'b1;
          mem_rdata = sel_rdata;
        end
      end
      ERR: begin
        mem_ready = 1'b1;
        bus_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_soc_bus_decoder.sv
// Self-checking bench for soc_bus_decoder: vector table, corner-case sequences and
// randomized transactions checked against a per-slave address map model.
module tb_soc_bus_decoder;

  localparam int NS = 4;
  localparam int TO = 8;
  localparam int NEVER = 99;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mem_valid;
  logic [31:0]   mem_addr;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [NS-1:0] slave_sel;
  logic [NS-1:0] slave_ready;
  logic [NS*32-1:0] slave_rdata;
  logic          bus_err;
  logic          err_timeout;
  logic [31:0]   err_addr;
  logic [15:0]   err_count;

  always #5 clk = ~clk;

  soc_bus_decoder #(
    .NUM_SLAVES(NS),
    .BASE_ADDRS({32'h8000_0010, 32'h8000_0008, 32'h8000_0000, 32'h0000_0000}),
    .ADDR_MASKS({32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'hFFFF_E000}),
    .TIMEOUT_CYCLES(TO),
    .DEFAULT_RDATA(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem_valid(mem_valid),
    .mem_addr(mem_addr),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .slave_sel(slave_sel),
    .slave_ready(slave_ready),
    .slave_rdata(slave_rdata),
    .bus_err(bus_err),
    .err_timeout(err_timeout),
    .err_addr(err_addr),
    .err_count(err_count)
  );

  // Address map as a plain per-slave table.
  logic [31:0] base_arr [NS] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0008, 32'h8000_0010};
  logic [31:0] mask_arr [NS] = '{32'hFFFF_E000, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'hFFFF_FFFF};

  typedef struct {
    logic [31:0] addr;
    int          delay;
    logic [31:0] data;
    logic [3:0]  exp_sel;
  } vec_t;

  int passed = 0;
  int total = 0;
  int exp_count = 0;
  logic prev_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & mask_arr[i]) == base_arr[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      check("ready_back_to_back", {31'b0, mem_ready && prev_ready}, 32'd0);
      prev_ready = mem_ready;
    end else begin
      prev_ready = 1'b0;
    end
  end

  task automatic drive_noise();
    slave_ready = 4'($urandom);
    slave_rdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check_err(input string tag, input logic [31:0] addr, input logic to);
    exp_count = (exp_count == 16'hFFFF) ? exp_count : exp_count + 1;
    check({tag, "_err_ready"}, {31'b0, mem_ready}, 32'd1);
    check({tag, "_err_pulse"}, {31'b0, bus_err}, 32'd1);
    check({tag, "_err_rdata"}, mem_rdata, 32'd0);
    check({tag, "_err_timeout"}, {31'b0, err_timeout}, {31'b0, to});
    check({tag, "_err_addr"}, err_addr, addr);
    check({tag, "_err_count"}, {16'b0, err_count}, exp_count);
    check({tag, "_err_sel"}, {28'b0, slave_sel}, 32'd0);
  endtask

  // One request: exp_sel==0 means unmapped; delay = sel cycles before ready (>=TO times out).
  task automatic apply_stimulus(input string tag, input logic [31:0] addr, input int delay,
                                input logic [31:0] data, input logic [3:0] exp_sel);
    int  idx;
    bit  done;
    done = 1'b0;
    idx = 0;
    for (int i = 0; i < NS; i++) if (exp_sel[i]) idx = i;
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    drive_noise();
    @(negedge clk);
    check({tag, "_idle_ready"}, {31'b0, mem_ready}, 32'd0);
    if (exp_sel == 4'b0) begin
      @(posedge clk); #1;
      drive_noise();
      @(negedge clk);
      check_err(tag, addr, 1'b0);
    end else begin
      for (int c = 0; c < TO; c++) begin
        @(posedge clk); #1;
        slave_ready = 4'($urandom) & ~exp_sel;
        if (c == delay) slave_ready[idx] = 1'b1;
        slave_rdata = {$urandom, $urandom, $urandom, $urandom};
        slave_rdata[32*idx +: 32] = data;
        @(negedge clk);
        check({tag, "_sel"}, {28'b0, slave_sel}, {28'b0, exp_sel});
        if (c == delay) begin
          check({tag, "_ready"}, {31'b0, mem_ready}, 32'd1);
          check({tag, "_rdata"}, mem_rdata, data);
          check({tag, "_no_err"}, {31'b0, bus_err}, 32'd0);
          done = 1'b1;
          break;
        end else begin
          check({tag, "_wait_ready"}, {31'b0, mem_ready}, 32'd0);
          check({tag, "_wait_rdata"}, mem_rdata, 32'd0);
        end
      end
      if (!done) begin
        @(posedge clk); #1;
        drive_noise();
        @(negedge clk);
        check_err(tag, addr, 1'b1);
      end
    end
    @(posedge clk); #1;
    mem_valid   = 1'b0;
    slave_ready = '0;
    @(negedge clk);
    check_output(tag);
  endtask

  task automatic check_output(input string tag);
    check({tag, "_end_sel"}, {28'b0, slave_sel}, 32'd0);
    check({tag, "_end_ready"}, {31'b0, mem_ready}, 32'd0);
    check({tag, "_end_count"}, {16'b0, err_count}, exp_count);
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{32'h0000_0100, 1,     32'hDEAD_BEEF, 4'b0001};
    vecs[1] = '{32'h8000_000C, 0,     32'h1234_5678, 4'b0100};
    vecs[2] = '{32'h4000_0000, 0,     32'h0,         4'b0000};
    vecs[3] = '{32'h8000_0010, NEVER, 32'hCAFE_0003, 4'b1000};
    vecs[4] = '{32'h8000_0010, 7,     32'hCAFE_0007, 4'b1000};
    vecs[5] = '{32'h8000_0000, 3,     32'hA5A5_0001, 4'b0010};
    vecs[6] = '{32'h0000_1FFF, 2,     32'h0BAD_F00D, 4'b0001};
    vecs[7] = '{32'h0000_2000, 0,     32'h0,         4'b0000};
    vecs[8] = '{32'h8000_0014, 0,     32'h0,         4'b0000};
    vecs[9] = '{32'h8000_0008, 5,     32'h5555_AAAA, 4'b0100};

    reset_n     = 1'b0;
    mem_valid   = 1'b0;
    mem_addr    = '0;
    slave_ready = '0;
    slave_rdata = '0;
    #12;
    check("reset_sel", {28'b0, slave_sel}, 32'd0);
    check("reset_ready", {31'b0, mem_ready}, 32'd0);
    check("reset_rdata", mem_rdata, 32'd0);
    check("reset_count", {16'b0, err_count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      apply_stimulus($sformatf("vec%0d", v), vecs[v].addr, vecs[v].delay, vecs[v].data, vecs[v].exp_sel);
    end

    // Request withdrawn while ACTIVE: no response, no error.
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = 32'h8000_0000;
    slave_ready = '0;
    @(posedge clk); #1;
    slave_ready = 4'b1101;
    @(negedge clk);
    check("abort_sel", {28'b0, slave_sel}, 32'd2);
    check("abort_wait", {31'b0, mem_ready}, 32'd0);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'b0, mem_ready}, 32'd0);
    check("abort_err", {31'b0, bus_err}, 32'd0);
    @(negedge clk);
    check_output("abort");

    // Reset in the middle of an ACTIVE transaction.
    @(posedge clk); #1;
    mem_valid   = 1'b1;
    mem_addr    = 32'h0000_0040;
    slave_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    exp_count = 0;
    check("midreset_sel", {28'b0, slave_sel}, 32'd0);
    check("midreset_ready", {31'b0, mem_ready}, 32'd0);
    check("midreset_err", {31'b0, bus_err}, 32'd0);
    check("midreset_to", {31'b0, err_timeout}, 32'd0);
    check("midreset_addr", err_addr, 32'd0);
    check("midreset_count", {16'b0, err_count}, 32'd0);
    check("midreset_rdata", mem_rdata, 32'd0);
    mem_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus("post_reset", 32'h0000_0100, 1, 32'hDEAD_BEEF, 4'b0001);

    for (int r = 0; r < 30; r++) begin
      logic [31:0] a;
      int          d;
      int          idx;
      case ($urandom_range(0, 5))
        0:       a = {19'b0, 13'($urandom)};
        1:       a = 32'h8000_0000;
        2:       a = 32'h8000_0008 + $urandom_range(0, 7);
        3:       a = 32'h8000_0010;
        4:       a = 32'h8000_0000 + $urandom_range(0, 31);
        default: a = $urandom;
      endcase
      d = $urandom_range(0, 9);
      idx = ref_decode(a);
      apply_stimulus($sformatf("rnd%0d", r), a, d, $urandom, (idx < 0) ? 4'b0 : 4'(1 << idx));
    end

    // Jump the counter near its ceiling instead of spending 131k cycles getting there.
    @(negedge clk);
    force dut.err_count = 16'hFFFD;
    @(posedge clk); #1;
    release dut.err_count;
    exp_count = 16'hFFFD;
    for (int s = 0; s < 4; s++) begin
      apply_stimulus($sformatf("sat%0d", s), 32'h4000_0000 + 32'(s), 0, 32'h0, 4'b0000);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
